// File: rtl/cache_data_array_nway.sv
// cache_data_array_nway: N-way set-associative cache data store.
// Flop-based SETS x WAYS x WORDS_PER_BLK word array with a registered
// single-word read port, a CPU write-hit port and a line-fill sequencer
// that writes one block from the memory side, one word per accepted beat.
// Optional build macro CDA_BYTE_WE_EN adds per-byte enables (wr_be) on
// CPU writes; fill beats always write full words.
//
// Fill sequencer states:
//   state | meaning
//   IDLE  | no fill in progress, CPU writes accepted
//   FILL  | writing beats of the latched set/way, one per fill_valid
//   DONE  | last beat written, fill_done pulses, back to IDLE next cycle
module cache_data_array_nway #(
    parameter int WORD_W        = 16,
    parameter int WORDS_PER_BLK = 8,
    parameter int SETS          = 64,
    parameter int WAYS          = 2,
    localparam int SET_W        = $clog2(SETS),
    localparam int WAY_W        = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int WRD_W        = $clog2(WORDS_PER_BLK)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [SET_W-1:0]  rd_set,
    input  logic [WAY_W-1:0]  rd_way,
    input  logic [WRD_W-1:0]  rd_word,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [SET_W-1:0]  wr_set,
    input  logic [WAY_W-1:0]  wr_way,
    input  logic [WRD_W-1:0]  wr_word,
    input  logic [WORD_W-1:0] wr_data,
`ifdef CDA_BYTE_WE_EN
    input  logic [WORD_W/8-1:0] wr_be,
`endif
    output logic              wr_ack,
    input  logic              fill_start,
    input  logic [SET_W-1:0]  fill_set,
    input  logic [WAY_W-1:0]  fill_way,
    input  logic              fill_valid,
    input  logic [WORD_W-1:0] fill_data,
    output logic              fill_busy,
    output logic              fill_done
);

    typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_t;

    localparam logic [WAY_W:0] WAYS_L = (WAY_W+1)'(WAYS);
    localparam logic [WRD_W-1:0] LAST_WORD = WRD_W'(WORDS_PER_BLK - 1);

    logic [WORD_W-1:0] mem [SETS][WAYS][WORDS_PER_BLK];

    fill_state_t       state;
    logic [WRD_W-1:0]  cnt;
    logic [SET_W-1:0]  fill_set_q;
    logic [WAY_W-1:0]  fill_way_q;

    logic              rd_way_ok;
    logic              wr_way_ok;
    logic              fill_way_ok;
    logic              fill_wr;
    logic [WORD_W-1:0] wr_merged;

    assign wr_ack      = wr_en & ~fill_busy;
    assign rd_way_ok   = {1'b0, rd_way} < WAYS_L;
    assign wr_way_ok   = {1'b0, wr_way} < WAYS_L;
    assign fill_way_ok = {1'b0, fill_way_q} < WAYS_L;
    assign fill_wr     = (state == FILL) && fill_valid;

    // CPU write data, merged with the stored word when byte enables exist
    always_comb begin
        wr_merged = wr_data;
`ifdef CDA_BYTE_WE_EN
        for (int b = 0; b < WORD_W/8; b++) begin
            if (!wr_be[b] && wr_way_ok) begin
                wr_merged[b*8 +: 8] = mem[wr_set][wr_way][wr_word][b*8 +: 8];
            end
        end
`endif
    end

    // Storage: CPU write hits and fill beats never coincide (CPU is blocked while busy)
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    for (int k = 0; k < WORDS_PER_BLK; k++) begin
                        mem[s][w][k] <= '0;
                    end
                end
            end
        end else begin
            if (wr_ack && wr_way_ok) begin
                mem[wr_set][wr_way][wr_word] <= wr_merged;
            end
            if (fill_wr && fill_way_ok) begin
                mem[fill_set_q][fill_way_q][cnt] <= fill_data;
            end
        end
    end

    // Registered read port; sees pre-write contents on same-cycle access
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_way_ok ? mem[rd_set][rd_way][rd_word] : '0;
            end
        end
    end

    // Line-fill sequencer with registered busy/done
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            fill_set_q <= '0;
            fill_way_q <= '0;
            fill_busy  <= 1'b0;
            fill_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fill_start) begin
                        fill_set_q <= fill_set;
                        fill_way_q <= fill_way;
                        cnt        <= '0;
                        fill_busy  <= 1'b1;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    if (fill_valid) begin
                        if (cnt == LAST_WORD) begin
                            cnt       <= '0;
                            fill_done <= 1'b1;
                            state     <= DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    fill_done <= 1'b0;
                    fill_busy <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    fill_done <= 1'b0;
                    fill_busy <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
